// File: rtl/sramgen_sram_arbiter_2p.sv
// Two-requester round-robin arbiter and zero-fill init sequencer for a single-port
// byte-masked SRAM macro with a 1-cycle registered read.
module sramgen_sram_arbiter_2p #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned WMASK_WIDTH   = 4,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstb,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [WMASK_WIDTH-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_din,
  output logic                   rsp0_valid,
  output logic [DATA_WIDTH-1:0]  rsp0_data,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [WMASK_WIDTH-1:0] req1_wmask,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0]  req1_din,
  output logic                   rsp1_valid,
  output logic [DATA_WIDTH-1:0]  rsp1_data,

  output logic                   init_done,

  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rd_pend0_q, rd_pend0_d;
  logic                  rd_pend1_q, rd_pend1_d;
  logic                  grant0, grant1;

  // State register; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= RESET_STATE;
      init_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rd_pend0_q   <= 1'b0;
      rd_pend1_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      rd_pend0_q   <= rd_pend0_d;
      rd_pend1_q   <= rd_pend1_d;
    end
  end

  // Next state, grant selection and macro drive
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_grant_d = last_grant_q;
    rd_pend0_d   = 1'b0;
    rd_pend1_d   = 1'b0;
    grant0       = 1'b0;
    grant1       = 1'b0;
    sram_we      = 1'b0;
    sram_wmask   = '0;
    sram_addr    = '0;
    sram_din     = '0;

    case (state_q)
      ST_INIT: begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = init_cnt_q;
        init_cnt_d = ADDR_WIDTH'(init_cnt_q + 1'b1);
        if (init_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // On a tie the requester not granted last time wins
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);

        if (grant0) begin
          sram_we      = req0_we;
          sram_wmask   = req0_wmask;
          sram_addr    = req0_addr;
          sram_din     = req0_din;
          last_grant_d = 1'b0;
          rd_pend0_d   = !req0_we;
        end else if (grant1) begin
          sram_we      = req1_we;
          sram_wmask   = req1_wmask;
          sram_addr    = req1_addr;
          sram_din     = req1_din;
          last_grant_d = 1'b1;
          rd_pend1_d   = !req1_we;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_done  = (state_q == ST_RUN);

  // Read data passes straight through; only the pending flag qualifies it
  assign rsp0_valid = rd_pend0_q;
  assign rsp1_valid = rd_pend1_q;
  assign rsp0_data  = sram_dout;
  assign rsp1_data  = sram_dout;

endmodule

// File: doc/sramgen_sram_arbiter_2p.md
# sramgen_sram_arbiter_2p

Two-requester arbiter and init sequencer for the single-port 32x32 byte-masked SRAM macro (1-cycle registered read, no chip enable). It zero-fills the array after reset, then grants one request per cycle using round-robin priority. Read data is steered back to the requester that issued the read. It sits directly in front of the macro; both requesters see a valid/ready request channel and an unbackpressured read-response channel.

## Interface
- DATA_WIDTH, 32, word width; must equal the macro's.
- ADDR_WIDTH, 5, address width; depth = 1<<ADDR_WIDTH.
- WMASK_WIDTH, 4, byte-lane write mask width; DATA_WIDTH/WMASK_WIDTH = 8.
- INIT_ON_RESET, 1, when 1 the block zero-fills the array after reset; when 0 it starts directly in RUN.

Ports:
- clk  in  1  clock, rising edge.
- rstb  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request valid, N = 0,1.
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_wmask  in  WMASK_WIDTH  byte-lane enables; ignored for reads.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_din  in  DATA_WIDTH  write data.
- rspN_valid  out  1  read data valid.
- rspN_data  out  DATA_WIDTH  read data.
- init_done  out  1  high once the block is in RUN.
- sram_we  out  1  macro write enable.
- sram_wmask  out  WMASK_WIDTH  macro write mask.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro write data.
- sram_dout  in  DATA_WIDTH  macro read data.

## Operation
- **States.**
  - INIT: entered on reset when INIT_ON_RESET=1.
  - RUN: entered on reset when INIT_ON_RESET=0.
  - No other transitions; RUN is terminal until the next reset.
- **INIT.**
  - Drive sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=init_cnt.
  - init_cnt starts at 0 and increments every cycle.
  - On the cycle init_cnt = depth-1, the next state is RUN.
  - Both reqN_ready=0; init_done=0.
- **RUN, grant rules.**
  - Only req0_valid asserted: grant 0.
  - Only req1_valid asserted: grant 1.
  - Both asserted: grant the requester not recorded in last_grant.
  - last_grant updates on every grant and resets to 1, so req0 wins the first tie.
  - reqN_ready = grantN. It is combinational from the valids and last_grant; at most one ready is high per cycle.
- **RUN, macro drive.**
  - sram_* outputs are a combinational mux of the granted request.
  - With no grant: sram_we=0, sram_addr=0, sram_wmask=0, sram_din=0. This is a harmless idle read, and no response is generated for it.
- **Read tracking.**
  - A granted read sets the registered flag rd_pendN for the next cycle; all other cycles clear it.
  - rspN_valid = rd_pendN.
  - rspN_data = sram_dout, passed through unconditionally. It is meaningful only while rspN_valid=1.
- **Writes.** Produce no response. The macro's dout is X on a write cycle; this never reaches a rspN_valid cycle.
- **Reset values.**
  - reqN_ready=0.
  - rspN_valid=0.
  - init_done = !INIT_ON_RESET.
  - init_cnt=0; last_grant=1; rd_pendN=0.
  - While rstb is low with INIT_ON_RESET=1, the sram_* outputs show an INIT write of 0 to address 0; this is permitted.

## Timing
- **Init duration.** INIT_ON_RESET=1: init_done rises in cycle `depth` after rstb deasserts, i.e. 32 cycles for the default depth. The first request can be accepted in that same cycle.
- **Read latency.** A read handshake at edge k gives rspN_valid=1 with the data during cycle k+1 (exactly 1 cycle). Back-to-back reads give one response per cycle.
- **Read after write.** A write accepted at edge k followed by a read of the same address at edge k+1 returns the new data at k+2.
- **Fairness.** Under continuous contention, grants alternate 0,1,0,1.
- **Reset mid-operation.** Asynchronously clears rd_pendN (any in-flight response is dropped) and returns the block to INIT (or RUN if INIT_ON_RESET=0). A reset during INIT restarts the fill at address 0.
- **Requester obligations.** reqN_* must be held stable while reqN_valid=1 and reqN_ready=0. Responses cannot be backpressured; the requester must always sink them.

## Test plan
- **Init fill.** Preload the model with nonzero data, pulse rstb, wait for init_done.
  - init_done rises exactly 32 cycles after reset release; no ready is asserted before that.
  - Reads of addresses 0..31 all return 0.
- **Masked write then read.** req0 writes 0xAABBCCDD to addr 5 with wmask=4'b0101, then reads addr 5 the next cycle.
  - rsp0_valid is high one cycle later with data 0x00BB00DD.
  - rsp1_valid stays 0.
- **Contention.** Hold req0 and req1 reads valid for 6 cycles.
  - Grants are 0,1,0,1,0,1.
  - Each rspN_valid pulses one cycle after its own grant with that requester's data.
- **Write/read collision.** In the same cycle, req0 writes 0x12345678 to addr 3 and req1 reads addr 3.
  - req0 is granted first; req1 is granted next and receives 0x12345678.
- **Reset mid-read.** Grant a req1 read, then assert rstb before the next edge.
  - rsp1_valid never rises.
  - The INIT sequence restarts from addr 0.
- **INIT_ON_RESET=0.**
  - init_done=1 immediately after reset.
  - A req0 read in the first cycle is accepted.
